// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer.
// Optional macro SHIFT_SEQ_NIBBLE_EN (used by shift_seq / shift_step) enables 4-bit steps.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Request/result handshake bundle between ALU issue logic and the shift sequencer.
// Macro SHIFT_SEQ_NIBBLE_EN does not affect this interface.
interface shift_seq_if #(parameter int N = 32);
  localparam int SHW = $clog2(N);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic [SHW-1:0] in_shamt;
  logic [1:0]     in_op;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic           busy;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts by 1, or by 4 when nib=1.
// The nib port and 4-bit path exist only when SHIFT_SEQ_NIBBLE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] data,
  input  shift_op_t    op,
`ifdef SHIFT_SEQ_NIBBLE_EN
  input  logic         nib,
`endif
  output logic [N-1:0] result
);

  logic [N-1:0] one_r;

  // Reserved op falls through to SLL.
  always_comb begin
    case (op)
      OP_SRL:  one_r = {1'b0, data[N-1:1]};
      OP_SRA:  one_r = {data[N-1], data[N-1:1]};
      default: one_r = {data[N-2:0], 1'b0};
    endcase
  end

`ifdef SHIFT_SEQ_NIBBLE_EN
  logic [N-1:0] four_r;

  always_comb begin
    case (op)
      OP_SRL:  four_r = {4'b0000, data[N-1:4]};
      OP_SRA:  four_r = {{4{data[N-1]}}, data[N-1:4]};
      default: four_r = {data[N-5:0], 4'b0000};
    endcase
  end

  assign result = nib ? four_r : one_r;
`else
  assign result = one_r;
`endif

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: FSM, shift counter and handshakes around shift_step.
// Define SHIFT_SEQ_NIBBLE_EN to take 4-bit steps while at least 4 positions remain.
//
// state   | meaning
// S_IDLE  | ready for a request; in_ready=1
// S_SHIFT | applying one step per clock until cnt_q reaches zero
// S_DONE  | result held on out_data with out_valid=1 until out_ready
module shift_seq
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_seq_if.slave  bus
);

  localparam int SHW = $clog2(N);

  seq_state_t     state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  shift_op_t      op_q, op_d;
  logic [N-1:0]   step_data;
  logic [SHW-1:0] k;

`ifdef SHIFT_SEQ_NIBBLE_EN
  logic nib;
  assign nib = (cnt_q >= SHW'(4));
  assign k   = nib ? SHW'(4) : SHW'(1);

  shift_step #(.N(N)) u_step (
    .data   (data_q),
    .op     (op_q),
    .nib    (nib),
    .result (step_data)
  );
`else
  assign k = SHW'(1);

  shift_step #(.N(N)) u_step (
    .data   (data_q),
    .op     (op_q),
    .result (step_data)
  );
`endif

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_data  = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          cnt_d   = bus.in_shamt;
          op_d    = shift_op_t'(bus.in_op);
          state_d = (bus.in_shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = step_data;
        cnt_d  = cnt_q - k;
        if (cnt_q == k) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: expected results and latencies come from a barrel-shift model.
// Honours SHIFT_SEQ_NIBBLE_EN for the expected latency.
module tb_shift_seq;

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  shift_seq_if #(.N(32)) bus ();

  shift_seq #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic [1:0] op);
    case (op)
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  function automatic int model_lat(input int s);
`ifdef SHIFT_SEQ_NIBBLE_EN
    return (s / 4) + (s % 4);
`else
    return s;
`endif
  endfunction

  // Returns just after the accept edge with in_valid dropped.
  task automatic send(input logic [31:0] d, input int s, input logic [1:0] op, input string name);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = 5'(s);
    bus.in_op    = op;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s accept_timeout in_ready never rose", name);
    end
    e.data = model(d, s, op);
    e.lat  = model_lat(s);
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Waits for the result, optionally stalls, then checks handoff back to IDLE.
  task automatic recv(input int stall, input logic poke);
    exp_t e;
    int cyc;
    logic [31:0] held;
    e = sb_q.pop_front();
    cyc = 0;
    @(negedge clk);
    while (!bus.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL %s done_timeout out_valid never rose", e.name);
      return;
    end
    checks++;
    if (cyc !== e.lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", e.name, cyc, e.lat);
    end
    checks++;
    if (bus.out_data !== e.data) begin
      errors++;
      $display("FAIL %s data got %h want %h", e.name, bus.out_data, e.data);
    end
    held = bus.out_data;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        bus.in_shamt = 5'd3;
        bus.in_op    = 2'b00;
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s stall%0d valid=%b data=%h ready=%b want 1 %h 0",
                 e.name, i, bus.out_valid, bus.out_data, bus.in_ready, held);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release ready=%b valid=%b busy=%b want 1 0 0",
               e.name, bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    bus.in_shamt = 5'd7;
    bus.in_op    = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset ready=%b valid=%b data=%h busy=%b want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.busy);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_sll();
    send(32'h0000_0001, 31, 2'b00, "sll31");
    recv(0, 1'b0);
    send(32'hA5A5_A5A5, 7, 2'b11, "rsv7");
    recv(0, 1'b0);
  endtask

  task automatic test_sra_srl();
    send(32'h8000_0000, 4, 2'b10, "sra4");
    recv(0, 1'b0);
    send(32'h8000_0000, 4, 2'b01, "srl4");
    recv(0, 1'b0);
    send(32'h8000_0000, 31, 2'b10, "sra31");
    recv(0, 1'b0);
  endtask

  task automatic test_zero();
    send(32'hDEAD_BEEF, 0, 2'b10, "zero");
    recv(0, 1'b0);
  endtask

  task automatic test_backpressure();
    send(32'h0F0F_0F0F, 5, 2'b01, "bp");
    recv(5, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_accept busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    send(32'h0000_0001, 20, 2'b00, "mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dropped = sb_q.pop_front();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL %s_reset busy=%b valid=%b ready=%b data=%h want 0 0 1 0",
               dropped.name, bus.busy, bus.out_valid, bus.in_ready, bus.out_data);
    end
    send(32'h0000_0001, 2, 2'b00, "post_rst");
    recv(0, 1'b0);
    send(32'h0000_0001, 13, 2'b00, "sll13");
    recv(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int s;
    logic [1:0] op;
    for (int i = 0; i < 24; i++) begin
      d  = $urandom;
      s  = (i < 4) ? (i * 8 + 7) % 32 : int'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      send(d, s, op, $sformatf("b2b%0d", i));
      recv(i % 3, 1'b0);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sll();
    test_sra_srl();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
